// File: rtl/invert_arbiter.sv
// Round-robin arbiter sharing one registered inverter between NUM_REQ requesters.
// Define INVERT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module invert_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  input  logic                          rsp_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INVERT = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   start_idx;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  found;
  logic                  accept;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

`ifdef INVERT_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (int'(win_idx) == NUM_REQ - 1)
               ? '0 : win_idx + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign start_idx = rr_ptr_q;
`endif

  // Circular search starting at start_idx; first valid wins.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start_idx) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = ID_WIDTH'(idx);
      end
    end
  end

  assign accept = (state_q == IDLE) && found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opnd_d  = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          id_d    = win_idx;
          state_d = INVERT;
        end
      end
      INVERT: begin
        rsp_data_d  = ~opnd_q;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
